inert_seq: RTL and testbench



---
 rtl/inert_seq_pkg.sv | 12 +
 rtl/inert_seq_if.sv | 7 +
 rtl/inert_seq_int_sync.sv | 13 +
 rtl/inert_seq.sv | 85 ++++++++
 tb/tb_inert_seq.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/inert_seq_pkg.sv
// inert_seq_pkg: FSM states, sensor init table and rate register map shared by inert_seq.
package inert_seq_pkg;
  typedef enum logic [2:0] {PWR_WAIT, INIT_WR, INIT_WAIT, IDLE, RD_WR, RD_WAIT, VALID} state_t;
  localparam logic [2:0][15:0] INIT_TBL = {16'h1440, 16'h1160, 16'h0D02};
  localparam logic [3:0][6:0] RD_ADDR = {7'h27, 7'h26, 7'h23, 7'h22};
  function automatic logic [15:0] init_word(input logic [1:0] i);
    return i == 2'd0 ? INIT_TBL[0] : i == 2'd1 ? INIT_TBL[1] : INIT_TBL[2];
  endfunction
  function automatic logic [15:0] rd_cmd(input logic [1:0] i);
    return {1'b1, RD_ADDR[i], 8'h00};
  endfunction
endpackage

// File: rtl/inert_seq_if.sv
// inert_seq_if: SPI monarch handshake plus rate outputs of the inertial sequencer.
interface inert_seq_if;
  logic INT, done, wrt, vld, init_done, err;
  logic [15:0] rd_data, wt_data, ptch_rt, yaw_rt;
  modport master (input INT, done, rd_data, output wrt, wt_data, ptch_rt, yaw_rt, vld, init_done, err);
  modport slave (output INT, done, rd_data, input wrt, wt_data, ptch_rt, yaw_rt, vld, init_done, err);
endinterface

// File: rtl/inert_seq_int_sync.sv
// inert_int_sync: three-flop synchronizer for the sensor INT line with rising-edge detect.
module inert_int_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);
  logic [2:0] s;
  always_ff @(posedge clk or posedge rst)
    if (rst) s <= '0;
    else s <= {s[1:0], din};
  assign rise = s[1] & ~s[2];
endmodule

// File: rtl/inert_seq.sv
// inert_seq: power-up delay, sensor init writes, then INT-driven pitch/yaw rate reads.
// Define INERT_TIMEOUT_EN to add an IDLE watchdog that flags err and re-inits the sensor.
module inert_seq import inert_seq_pkg::*; #(
  parameter int PWR_DLY_W = 16,
  parameter int TMO_W = 20
) (
  input logic clk,
  input logic rst,
  inert_seq_if.master bus
);
  state_t state;
  logic [PWR_DLY_W-1:0] pcnt;
  logic [1:0] idx, ridx;
  logic [2:0][7:0] b;
  logic rise, unused_hi;
  inert_int_sync u_sync (.clk, .rst, .din(bus.INT), .rise);
  assign unused_hi = ^bus.rd_data[15:8];
  assign bus.wrt = state == INIT_WR || state == RD_WR;
  assign bus.wt_data = (state == INIT_WR || state == INIT_WAIT) ? init_word(idx) :
                       (state == RD_WR || state == RD_WAIT) ? rd_cmd(ridx) : 16'h0000;
  assign bus.vld = state == VALID;
`ifdef INERT_TIMEOUT_EN
  logic [TMO_W-1:0] tmo;
  logic err_q;
  assign bus.err = err_q;
`else
  logic [TMO_W-1:0] unused_tmo;
  assign unused_tmo = '0;
  assign bus.err = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= PWR_WAIT;
      pcnt <= '0;
      idx <= '0;
      ridx <= '0;
      b <= '0;
      bus.ptch_rt <= '0;
      bus.yaw_rt <= '0;
      bus.init_done <= 1'b0;
`ifdef INERT_TIMEOUT_EN
      tmo <= '0;
      err_q <= 1'b0;
`endif
    end else begin
`ifdef INERT_TIMEOUT_EN
      tmo <= state == IDLE && !rise ? tmo + TMO_W'(1) : '0;
`endif
      case (state)
        PWR_WAIT: if (&pcnt) state <= INIT_WR; else pcnt <= pcnt + PWR_DLY_W'(1);
        INIT_WR: state <= INIT_WAIT;
        INIT_WAIT: if (bus.done) begin
          idx <= idx == 2'd2 ? 2'd0 : idx + 2'd1;
          if (idx == 2'd2) bus.init_done <= 1'b1;
          state <= idx == 2'd2 ? IDLE : INIT_WR;
        end
        IDLE: if (rise) begin
          ridx <= '0;
          state <= RD_WR;
        end
`ifdef INERT_TIMEOUT_EN
        else if (&tmo) begin
          err_q <= 1'b1;
          bus.init_done <= 1'b0;
          idx <= '0;
          state <= INIT_WR;
        end
`endif
        RD_WR: state <= RD_WAIT;
        // bytes arrive in order, so a shift register leaves b[0..2] = bytes 0..2
        RD_WAIT: if (bus.done) begin
          if (ridx == 2'd3) begin
            bus.ptch_rt <= {b[1], b[0]};
            bus.yaw_rt <= {bus.rd_data[7:0], b[2]};
            state <= VALID;
          end else begin
            b <= {bus.rd_data[7:0], b[2:1]};
            ridx <= ridx + 2'd1;
            state <= RD_WR;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_inert_seq.sv
// tb_inert_seq: directed bench for inert_seq with an SPI monarch + sensor register model.
`timescale 1ns/1ps
module tb_inert_seq;
  logic clk = 1'b0, rst = 1'b1;
  logic int_in = 1'b0, done_f = 1'b0, done_m = 1'b0;
  logic [15:0] rd_m = '0;
  int checks = 0, errors = 0;
  inert_seq_if ifc ();
  assign ifc.INT = int_in;
  assign ifc.done = done_m | done_f;
  assign ifc.rd_data = rd_m;
`ifdef INERT_TIMEOUT_EN
  inert_seq #(.PWR_DLY_W(4), .TMO_W(8)) dut (.clk(clk), .rst(rst), .bus(ifc));
`else
  inert_seq #(.PWR_DLY_W(4)) dut (.clk(clk), .rst(rst), .bus(ifc));
`endif
  always #5 clk = ~clk;

  // monarch: wrt starts a 4-cycle transfer ending in a one-cycle done; sensor registers behind it
  logic [7:0] regs [128];
  logic [7:0] rate [4];
  logic [15:0] wlog [256];
  logic [15:0] cmd = '0;
  logic busy = 1'b0;
  int mcnt = 0, n_wrt = 0, n_vld = 0;
  wire nemo_setup = regs[7'h0D] === 8'h02 && regs[7'h11] === 8'h60 && regs[7'h14] === 8'h40;
  function automatic logic [7:0] rd_val(input logic [6:0] a);
    return a == 7'h22 ? rate[0] : a == 7'h23 ? rate[1] : a == 7'h26 ? rate[2] : a == 7'h27 ? rate[3] : 8'h00;
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) begin
      busy <= 1'b0;
      done_m <= 1'b0;
      mcnt <= 0;
    end else begin
      done_m <= 1'b0;
      if (ifc.wrt) begin
        busy <= 1'b1;
        mcnt <= 0;
        cmd <= ifc.wt_data;
        wlog[n_wrt] <= ifc.wt_data;
        n_wrt <= n_wrt + 1;
      end else if (busy) begin
        if (mcnt == 3) begin
          busy <= 1'b0;
          done_m <= 1'b1;
          if (cmd[15]) rd_m <= {8'h00, rd_val(cmd[14:8])};
          else regs[cmd[14:8]] <= cmd[7:0];
        end else mcnt <= mcnt + 1;
      end
    end
  always @(posedge clk) if (ifc.vld) n_vld <= n_vld + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_init(input int lim);
    int k = 0;
    while (ifc.init_done !== 1'b1 && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("init_done", ifc.init_done, 1);
  endtask
  task automatic wait_vld(input int lim, output int k);
    k = 0;
    while (ifc.vld !== 1'b1 && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("vld_seen", ifc.vld, 1);
  endtask
  task automatic pwr_and_init(input string tag);
    int w = 0, base;
    base = n_wrt;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ifc.wrt) w++;
    end
    chk({tag, "_no_wrt_in_delay"}, w, 0);
    @(negedge clk);
    chk({tag, "_first_wrt"}, ifc.wrt, 1);
    chk({tag, "_first_word"}, ifc.wt_data, 16'h0D02);
    wait_init(100);
    chk({tag, "_init_wr_count"}, n_wrt - base, 3);
    chk({tag, "_init0"}, wlog[base], 16'h0D02);
    chk({tag, "_init1"}, wlog[base+1], 16'h1160);
    chk({tag, "_init2"}, wlog[base+2], 16'h1440);
  endtask
  task automatic chk_burst(input string tag, input int base);
    chk({tag, "_rd_count"}, n_wrt - base, 4);
    chk({tag, "_rd0"}, wlog[base], 16'hA200);
    chk({tag, "_rd1"}, wlog[base+1], 16'hA300);
    chk({tag, "_rd2"}, wlog[base+2], 16'hA600);
    chk({tag, "_rd3"}, wlog[base+3], 16'hA700);
  endtask

  initial begin
    int base, v0, k;
    rate = '{8'h34, 8'h12, 8'hDC, 8'hFE};
    cyc(3);
    chk("rst_wrt", ifc.wrt, 0);
    chk("rst_vld", ifc.vld, 0);
    chk("rst_init_done", ifc.init_done, 0);
    chk("rst_wt_data", ifc.wt_data, 0);
    chk("rst_ptch", ifc.ptch_rt, 0);
    chk("rst_yaw", ifc.yaw_rt, 0);
    chk("rst_err", ifc.err, 0);
    rst = 1'b0;
    pwr_and_init("pwr");
    chk("nemo_setup", nemo_setup, 1);

    base = n_wrt;
    v0 = n_vld;
    int_in = 1'b1;
    wait_vld(60, k);
    chk("int_to_vld_latency", k, 27);
    chk("ptch1", ifc.ptch_rt, 16'h1234);
    chk("yaw1", ifc.yaw_rt, 16'hFEDC);
    cyc(1);
    chk("vld_one_cycle", ifc.vld, 0);
    cyc(5);
    chk_burst("b1", base);
    chk("b1_vld_count", n_vld - v0, 1);
    chk("ptch1_hold", ifc.ptch_rt, 16'h1234);
    int_in = 1'b0;
    cyc(3);

    rate = '{8'h78, 8'h56, 8'hBC, 8'h9A};
    base = n_wrt;
    v0 = n_vld;
    int_in = 1'b1;
    cyc(8);
    int_in = 1'b0;
    cyc(3);
    int_in = 1'b1;
    wait_vld(60, k);
    cyc(40);
    chk_burst("b2", base);
    chk("b2_vld_count", n_vld - v0, 1);
    chk("ptch2", ifc.ptch_rt, 16'h5678);
    chk("yaw2", ifc.yaw_rt, 16'h9ABC);
    int_in = 1'b0;
    cyc(3);

    rate = '{8'h00, 8'h80, 8'hFF, 8'h7F};
    base = n_wrt;
    v0 = n_vld;
    int_in = 1'b1;
    wait_vld(60, k);
    cyc(5);
    chk_burst("b3", base);
    chk("b3_vld_count", n_vld - v0, 1);
    chk("ptch3", ifc.ptch_rt, 16'h8000);
    chk("yaw3", ifc.yaw_rt, 16'h7FFF);
    int_in = 1'b0;
    cyc(3);

    base = n_wrt;
    done_f = 1'b1;
    cyc(3);
    done_f = 1'b0;
    cyc(3);
    chk("idle_done_no_wrt", n_wrt - base, 0);
    chk("idle_done_init", ifc.init_done, 1);
    chk("idle_done_wt_data", ifc.wt_data, 0);

    base = n_wrt;
    int_in = 1'b1;
    k = 0;
    while (n_wrt - base < 2 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("second_rd_started", n_wrt - base, 2);
    cyc(2);
    rst = 1'b1;
    #1;
    chk("mid_rst_wrt", ifc.wrt, 0);
    chk("mid_rst_vld", ifc.vld, 0);
    chk("mid_rst_init_done", ifc.init_done, 0);
    chk("mid_rst_ptch", ifc.ptch_rt, 0);
    int_in = 1'b0;
    cyc(2);
    rst = 1'b0;
    pwr_and_init("re");

`ifdef INERT_TIMEOUT_EN
    base = n_wrt;
    cyc(200);
    chk("wdog_quiet", ifc.err, 0);
    k = 0;
    while (ifc.err !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("wdog_err", ifc.err, 1);
    chk("wdog_init_cleared", ifc.init_done, 0);
    wait_init(100);
    chk("wdog_reinit_count", n_wrt - base, 3);
    chk("wdog_reinit0", wlog[base], 16'h0D02);
    chk("wdog_reinit2", wlog[base+2], 16'h1440);
    chk("wdog_err_sticky", ifc.err, 1);
`else
    chk("err_tied_low", ifc.err, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
